// File: rtl/core_csr_unit.sv
// core_csr_unit: CSR block holding the non-cacheable address windows, a keyed
// watchdog with sticky status, and a free-running 64-bit cycle counter.
// Ports:
//   clk, rst_n                       core clock, async active-low reset
//   csr_req/we/addr/wdata            single-cycle CSR access (word index)
//   csr_ack/rdata/err                registered response, one cycle after request
//   ncache_base/mask/en              window i at [32i+31:32i] (en bit i)
//   wdt_timeout                      one-cycle pulse per watchdog expiry
//   wdt_expired                      sticky expiry level (STATUS[0])
module core_csr_unit #(
  parameter int unsigned NREGION     = 2,
  parameter int unsigned TIMER_W     = 32,
  parameter logic [31:0] NC_BASE_RST = 32'h8000_0000,
  parameter logic [31:0] NC_MASK_RST = 32'hF000_0000,
  parameter logic [31:0] WDT_KEY     = 32'h5A5A_A5A5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      csr_req,
  input  logic                      csr_we,
  input  logic [7:0]                csr_addr,
  input  logic [31:0]               csr_wdata,
  output logic                      csr_ack,
  output logic [31:0]               csr_rdata,
  output logic                      csr_err,
  output logic [32*NREGION-1:0]     ncache_base,
  output logic [32*NREGION-1:0]     ncache_mask,
  output logic [NREGION-1:0]        ncache_en,
  output logic                      wdt_timeout,
  output logic                      wdt_expired
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CYC_W  = 64;
  localparam int unsigned A_WIN  = 16;

  localparam logic [7:0] A_ID     = 8'h00;
  localparam logic [7:0] A_CTRL   = 8'h01;
  localparam logic [7:0] A_LOAD   = 8'h02;
  localparam logic [7:0] A_KICK   = 8'h03;
  localparam logic [7:0] A_COUNT  = 8'h04;
  localparam logic [7:0] A_STATUS = 8'h05;
  localparam logic [7:0] A_CYC_LO = 8'h06;
  localparam logic [7:0] A_CYC_HI = 8'h07;
  localparam logic [7:0] A_NC_EN  = 8'h08;

  logic [DATA_W-1:0]  r_base [NREGION];
  logic [DATA_W-1:0]  r_mask [NREGION];
  logic [NREGION-1:0] r_nc_en;
  logic               r_wdt_en;
  logic [TIMER_W-1:0] r_load;
  logic [TIMER_W-1:0] r_count;
  logic [1:0]         r_status;
  logic [CYC_W-1:0]   r_cycle;
  logic [DATA_W-1:0]  r_shadow;

  logic               w_wr;
  logic               w_rd;
  logic               w_kick_ok;
  logic               w_kick_bad;
  logic               w_en_rise;
  logic               w_sts_wr;
  logic               w_expire;
  logic               w_hit;
  logic [DATA_W-1:0]  w_rdata;

  // Access decode and watchdog event qualifiers
  assign w_wr       = csr_req & csr_we;
  assign w_rd       = csr_req & ~csr_we;
  assign w_kick_ok  = w_wr && (csr_addr == A_KICK) && (csr_wdata == WDT_KEY);
  assign w_kick_bad = w_wr && (csr_addr == A_KICK) && (csr_wdata != WDT_KEY);
  assign w_en_rise  = w_wr && (csr_addr == A_CTRL) && csr_wdata[0] && !r_wdt_en;
  assign w_sts_wr   = w_wr && (csr_addr == A_STATUS);
  // A valid kick in the same cycle suppresses expiry
  assign w_expire   = r_wdt_en && (r_count == '0) && !w_kick_ok;

  // Read mux; w_hit low flags an unmapped address
  always_comb begin
    w_rdata = '0;
    w_hit   = 1'b1;
    case (csr_addr)
      A_ID:     w_rdata = {16'h5E1E, 8'(NREGION), 8'(TIMER_W)};
      A_CTRL:   w_rdata = {31'd0, r_wdt_en};
      A_LOAD:   w_rdata = 32'(r_load);
      A_KICK:   w_rdata = '0;
      A_COUNT:  w_rdata = 32'(r_count);
      A_STATUS: w_rdata = {30'd0, r_status};
      A_CYC_LO: w_rdata = r_cycle[31:0];
      A_CYC_HI: w_rdata = r_shadow;
      A_NC_EN:  w_rdata = 32'(r_nc_en);
      default: begin
        w_hit = 1'b0;
        for (int i = 0; i < NREGION; i++) begin
          if (csr_addr == 8'(A_WIN + 2*i)) begin
            w_rdata = r_base[i];
            w_hit   = 1'b1;
          end
          if (csr_addr == 8'(A_WIN + 2*i + 1)) begin
            w_rdata = r_mask[i];
            w_hit   = 1'b1;
          end
        end
      end
    endcase
  end

  // All architectural state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_ack     <= 1'b0;
      csr_err     <= 1'b0;
      csr_rdata   <= '0;
      wdt_timeout <= 1'b0;
      r_wdt_en    <= 1'b0;
      r_load      <= '1;
      r_count     <= '1;
      r_status    <= '0;
      r_cycle     <= '0;
      r_shadow    <= '0;
      r_nc_en     <= NREGION'(1);
      for (int i = 0; i < NREGION; i++) begin
        r_base[i] <= (i == 0) ? NC_BASE_RST : '0;
        r_mask[i] <= (i == 0) ? NC_MASK_RST : '0;
      end
    end else begin
      csr_ack   <= csr_req;
      csr_err   <= csr_req & ~w_hit;
      csr_rdata <= w_rd ? w_rdata : '0;

      r_cycle <= r_cycle + 64'd1;
      // Snapshot the upper half so a following HI read pairs with this LO read
      if (w_rd && (csr_addr == A_CYC_LO)) r_shadow <= r_cycle[63:32];

      if (w_wr && (csr_addr == A_CTRL))  r_wdt_en <= csr_wdata[0];
      if (w_wr && (csr_addr == A_LOAD))  r_load   <= csr_wdata[TIMER_W-1:0];
      if (w_wr && (csr_addr == A_NC_EN)) r_nc_en  <= csr_wdata[NREGION-1:0];
      for (int i = 0; i < NREGION; i++) begin
        if (w_wr && (csr_addr == 8'(A_WIN + 2*i)))     r_base[i] <= csr_wdata;
        if (w_wr && (csr_addr == 8'(A_WIN + 2*i + 1))) r_mask[i] <= csr_wdata;
      end

      // Watchdog counter: reload on enable edge or kick, else count down and
      // reload on expiry so the dog keeps running
      if (w_en_rise || w_kick_ok) begin
        r_count <= r_load;
      end else if (r_wdt_en) begin
        r_count <= (r_count == '0) ? r_load : r_count - TIMER_W'(1);
      end

      wdt_timeout <= w_expire;
      // Sticky W1C status; a same-cycle set wins over the clear
      r_status[0] <= (r_status[0] & ~(w_sts_wr & csr_wdata[0])) | w_expire;
      r_status[1] <= (r_status[1] & ~(w_sts_wr & csr_wdata[1])) | w_kick_bad;
    end
  end

  // Flatten window registers onto the output buses
  for (genvar g = 0; g < NREGION; g++) begin : g_win
    assign ncache_base[32*g +: 32] = r_base[g];
    assign ncache_mask[32*g +: 32] = r_mask[g];
  end
  assign ncache_en   = r_nc_en;
  assign wdt_expired = r_status[0];

endmodule

// File: tb/tb_core_csr_unit.sv
// tb_core_csr_unit: directed plus randomized stimulus for core_csr_unit with
// default parameters (NREGION=2, TIMER_W=32). Expected values come from the
// bench's own register map model and from watchdog period arithmetic.
module tb_core_csr_unit;

  localparam logic [31:0] KEY = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [31:0] wdata = 32'd0;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic [63:0] nbase;
  logic [63:0] nmask;
  logic [1:0]  nen;
  logic        timeout;
  logic        expired;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_v;
  logic        er_v;

  // Reference model state for the randomized register phase
  logic [31:0] m_base [2];
  logic [31:0] m_mask [2];
  logic [1:0]  m_en;
  logic [31:0] m_load;
  logic [31:0] m_count;

  core_csr_unit #(.NREGION(2), .TIMER_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_req(req), .csr_we(we), .csr_addr(addr), .csr_wdata(wdata),
    .csr_ack(ack), .csr_rdata(rdata), .csr_err(err),
    .ncache_base(nbase), .ncache_mask(nmask), .ncache_en(nen),
    .wdt_timeout(timeout), .wdt_expired(expired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access, one clock; leaves time just after the response edge
  task automatic csr(input logic w, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    chk("ack", 64'(ack), 64'd1);
    rd_v = rdata;
    er_v = err;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    csr(1'b0, a, 32'd0);
    chk(tag, 64'(rd_v), 64'(exp));
    chk("rd_err", 64'(er_v), 64'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    csr(1'b1, a, d);
    chk("wr_err", 64'(er_v), 64'd0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // {err, data} the register map should answer with (EN=0, STATUS clear)
  function automatic logic [32:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return {1'b0, 32'h5E1E_0220};
      8'h01, 8'h03, 8'h05, 8'h06, 8'h07: return {1'b0, 32'h0};
      8'h02: return {1'b0, m_load};
      8'h04: return {1'b0, m_count};
      8'h08: return {1'b0, 30'd0, m_en};
      8'h10: return {1'b0, m_base[0]};
      8'h11: return {1'b0, m_mask[0]};
      8'h12: return {1'b0, m_base[1]};
      8'h13: return {1'b0, m_mask[1]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic logic [7:0] rand_unmapped();
    if ($urandom_range(0, 1) == 0) return 8'($urandom_range(9, 15));
    return 8'($urandom_range(20, 255));
  endfunction

  initial begin
    logic [63:0] prev;
    logic [63:0] cur;
    logic [31:0] lo;
    logic [31:0] hi;
    int unsigned ld;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_expired", 64'(expired), 64'd0);
    chk("rst_base", nbase, 64'h0000_0000_8000_0000);
    chk("rst_mask", nmask, 64'h0000_0000_F000_0000);
    chk("rst_en", 64'(nen), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    rd_chk("id", 8'h00, 32'h5E1E_0220);
    rd_chk("base0", 8'h10, 32'h8000_0000);
    rd_chk("mask0", 8'h11, 32'hF000_0000);
    rd_chk("nc_en", 8'h08, 32'h1);
    for (int i = 0; i < 3; i++) rd_chk("count_idle", 8'h04, 32'hFFFF_FFFF);

    // Watchdog LOAD=5: pulse every 6 cycles, W1C of STATUS in between
    wr(8'h02, 32'd5);
    wr(8'h01, 32'd1);
    for (int k = 1; k <= 18; k++) begin
      if (k == 7) rd_chk("status_set", 8'h05, 32'h1);
      else if (k == 8) wr(8'h05, 32'h1);
      else if (k == 9) rd_chk("status_clr", 8'h05, 32'h0);
      else idle();
      chk("wdt_pulse", 64'(timeout), 64'((k % 6) == 0));
      chk("wdt_expired", 64'(expired), 64'(((k >= 6) && (k < 8)) || (k >= 12)));
    end
    wr(8'h01, 32'd0);
    wr(8'h05, 32'h3);

    // LOAD=3, kicked exactly when COUNT reaches 0: never expires
    wr(8'h02, 32'd3);
    wr(8'h01, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      if ((k % 4) == 0) wr(8'h03, KEY);
      else idle();
      chk("kick_nopulse", 64'(timeout), 64'd0);
    end
    wr(8'h01, 32'd0);
    rd_chk("count_after_kick", 8'h04, 32'd2);
    wr(8'h03, 32'h1234_5678);
    rd_chk("count_bad_kick", 8'h04, 32'd2);
    rd_chk("status_bad_kick", 8'h05, 32'h2);
    chk("expired_bad_kick", 64'(expired), 64'd0);
    wr(8'h05, 32'h3);

    // Random LOAD values: pulses land on multiples of LOAD+1
    for (int it = 0; it < 3; it++) begin
      ld = $urandom_range(0, 7);
      wr(8'h02, 32'(ld));
      wr(8'h01, 32'd1);
      for (int k = 1; k <= 3 * (int'(ld) + 1) + 2; k++) begin
        if (k == 3 * (int'(ld) + 1) + 2) wr(8'h01, 32'd0);
        else idle();
        chk("rand_pulse", 64'(timeout), 64'((k % (int'(ld) + 1)) == 0));
      end
      wr(8'h05, 32'h3);
      rd_chk("rand_status_clr", 8'h05, 32'h0);
    end

    // Window 1 programming, outputs follow at the ack edge
    wr(8'h12, 32'h4000_0000);
    chk("base1_out", 64'(nbase[63:32]), 64'h4000_0000);
    wr(8'h13, 32'hFFFF_0000);
    chk("mask1_out", 64'(nmask[63:32]), 64'hFFFF_0000);
    wr(8'h08, 32'h3);
    chk("en_out", 64'(nen), 64'd3);
    rd_chk("base1_rd", 8'h12, 32'h4000_0000);
    rd_chk("mask1_rd", 8'h13, 32'hFFFF_0000);
    rd_chk("en_rd", 8'h08, 32'h3);

    // Unmapped accesses error out and change nothing; RO writes are silent
    csr(1'b0, 8'h3F, 32'd0);
    chk("unm_rd_data", 64'(rd_v), 64'd0);
    chk("unm_rd_err", 64'(er_v), 64'd1);
    csr(1'b1, 8'h3F, 32'hDEAD_BEEF);
    chk("unm_wr_err", 64'(er_v), 64'd1);
    csr(1'b1, 8'h14, 32'hDEAD_BEEF);
    chk("unm14_wr_err", 64'(er_v), 64'd1);
    csr(1'b0, 8'h14, 32'd0);
    chk("unm14_rd_err", 64'(er_v), 64'd1);
    chk("unm14_rd_data", 64'(rd_v), 64'd0);
    wr(8'h00, 32'h0BAD_0BAD);
    rd_chk("id_after_ro_wr", 8'h00, 32'h5E1E_0220);
    chk("unm_base_keep", nbase, 64'h4000_0000_8000_0000);
    chk("unm_mask_keep", nmask, 64'hFFFF_0000_F000_0000);

    // Randomized register traffic against the map model
    m_base[0] = 32'h8000_0000; m_mask[0] = 32'hF000_0000;
    m_base[1] = 32'h4000_0000; m_mask[1] = 32'hFFFF_0000;
    m_en = 2'b11;
    m_load = $urandom;
    wr(8'h02, m_load);
    wr(8'h03, KEY);
    m_count = m_load;
    for (int n = 0; n < 60; n++) begin
      logic [7:0]  a;
      logic [31:0] d;
      logic [32:0] m;
      int unsigned sel;
      d = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        case ($urandom_range(0, 5))
          0: a = 8'h02;
          1: a = 8'h08;
          2: a = 8'h10;
          3: a = 8'h11;
          4: a = 8'h12;
          default: a = 8'h13;
        endcase
        wr(a, d);
        case (a)
          8'h02: m_load = d;
          8'h08: m_en = d[1:0];
          8'h10: m_base[0] = d;
          8'h11: m_mask[0] = d;
          8'h12: m_base[1] = d;
          default: m_mask[1] = d;
        endcase
      end else if (sel == 1) begin
        case ($urandom_range(0, 3))
          0: a = 8'h00;
          1: a = 8'h04;
          2: a = 8'h07;
          default: a = rand_unmapped();
        endcase
        csr(1'b1, a, d);
        m = m_read(a);
        chk("rand_wr_err", 64'(er_v), 64'(m[32]));
      end else begin
        case ($urandom_range(0, 11))
          0: a = 8'h00;
          1: a = 8'h01;
          2: a = 8'h02;
          3: a = 8'h03;
          4: a = 8'h04;
          5: a = 8'h05;
          6: a = 8'h08;
          7: a = 8'h10;
          8: a = 8'h11;
          9: a = 8'h12;
          10: a = 8'h13;
          default: a = rand_unmapped();
        endcase
        csr(1'b0, a, 32'd0);
        m = m_read(a);
        chk("rand_rd_data", 64'(rd_v), 64'(m[31:0]));
        chk("rand_rd_err", 64'(er_v), 64'(m[32]));
      end
      chk("rand_base_out", nbase, {m_base[1], m_base[0]});
      chk("rand_mask_out", nmask, {m_mask[1], m_mask[0]});
      chk("rand_en_out", 64'(nen), 64'(m_en));
    end

    // Cycle counter LO/HI pairs across a forced low-word wrap
    @(negedge clk);
    force dut.r_cycle = 64'h0000_0000_FFFF_FFF8;
    @(negedge clk);
    release dut.r_cycle;
    prev = '0;
    hi = '0;
    for (int i = 0; i < 8; i++) begin
      csr(1'b0, 8'h06, 32'd0);
      lo = rd_v;
      csr(1'b0, 8'h07, 32'd0);
      hi = rd_v;
      cur = {hi, lo};
      if (i > 0) chk("cycle_step", cur - prev, 64'd2);
      prev = cur;
    end
    chk("cycle_wrap_hi", 64'(hi), 64'd1);

    // Reset asserted mid-access with the watchdog firing every cycle
    wr(8'h02, 32'd0);
    wr(8'h01, 32'd1);
    idle();
    idle();
    chk("pre_rst_expired", 64'(expired), 64'd1);
    chk("pre_rst_timeout", 64'(timeout), 64'd1);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 8'h12; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #2;
    chk("inflight_ack", 64'(ack), 64'd1);
    chk("inflight_base1", 64'(nbase[63:32]), 64'hCAFE_F00D);
    rst_n = 1'b0;
    #1;
    req = 1'b0; we = 1'b0;
    chk("arst_ack", 64'(ack), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_rdata", 64'(rdata), 64'd0);
    chk("arst_timeout", 64'(timeout), 64'd0);
    chk("arst_expired", 64'(expired), 64'd0);
    chk("arst_base", nbase, 64'h0000_0000_8000_0000);
    chk("arst_mask", nmask, 64'h0000_0000_F000_0000);
    chk("arst_en", 64'(nen), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_count", 8'h04, 32'hFFFF_FFFF);
    rd_chk("post_rst_load", 8'h02, 32'hFFFF_FFFF);
    rd_chk("post_rst_ctrl", 8'h01, 32'h0);
    rd_chk("post_rst_status", 8'h05, 32'h0);
    rd_chk("post_rst_base1", 8'h12, 32'h0);
    idle();
    chk("post_rst_timeout", 64'(timeout), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
